tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Controller in front of the `tone` generator (125 MHz `clk`; enables `EN392`/`EN110`) in the button-sequence-detect design.
- Converts single-cycle result events from the sequence detector into timed beep patterns:
  - correct code → repeated 392 Hz beeps;
  - wrong code → 110 Hz buzz.
- Arbitrates the two requesters onto the single tone resource; guarantees the two enables are never active together.

Parameters:
- TONE_CYC, 12500000, cycles each beep is held (100 ms at 125 MHz); legal range 1 to 2^24-1.
- GAP_CYC, 1250000, silent cycles after every beep, including the last (10 ms); legal range 1 to 2^24-1.
- OK_BEEPS, 2, number of 392 Hz beeps per ok pattern, 1..15.
- ERR_BEEPS, 1, number of 110 Hz beeps per err pattern, 1..15.

Ports:
- clk  input  1  system clock, 125 MHz
- rst  input  1  synchronous reset, active-high
- play_ok  input  1  request ok pattern; single-cycle pulse
- play_err  input  1  request err pattern; single-cycle pulse
- en392  output  1  drives tone `EN392`; registered
- en110  output  1  drives tone `EN110`; registered
- busy  output  1  high while a pattern is playing or a request is pending; registered

Behaviour:
- One clock (`clk`). Reset is synchronous and active-high (`rst`).
- Reset state: en392=0, en110=0, busy=0, state=IDLE, pending flags cleared, counters zero.
- `rst` mid-pattern: all outputs 0 on the next edge; pattern and pending requests discarded.
- States:
  - IDLE: no pattern active.
  - TONE: selected enable high.
  - GAP: both enables low.
- One 24-bit cycle counter and one 4-bit beep counter. A latched `sel` bit (0=ok, 1=err) selects the enable.
- IDLE → TONE:
  - Trigger: a request (play_* or pending flag) sampled at edge N.
  - en/busy go high at edge N+1 (1-cycle latency).
  - Counter loads TONE_CYC-1.
- TONE: selected enable held exactly TONE_CYC cycles. At counter 0 → GAP, counter loads GAP_CYC-1.
- GAP: both enables low exactly GAP_CYC cycles. At counter 0:
  - beeps remaining → TONE;
  - pattern done, pending flag set → TONE of pending pattern (served directly, no IDLE cycle);
  - otherwise → IDLE, busy drops the same edge.
- Arbitration:
  - play_ok and play_err together in IDLE → err served; ok latched pending.
  - Pending service order: err before ok.
- Requests while busy set a 1-bit pending flag per type.
  - Repeated requests of the same type collapse into one.
  - A request of the currently playing type is also queued.
- Invariant: en392 & en110 == 0 every cycle.

Optional Feature:
- Macro: TONE_SEQ_PREEMPT_EN.
- Defined:
  - play_err sampled during an ok pattern's TONE or GAP aborts it.
  - Next edge: en392=0, enter GAP with counter GAP_CYC-1, sel=err, beep counter reloaded to ERR_BEEPS.
  - Err tone starts after that gap; aborted ok pattern is dropped, not re-queued.
- Undefined: err during ok is queued as described above; no abort logic synthesised.

Decomposition:
- Package `tone_seq_pkg`:
  - state encoding constants (IDLE=2'd0, TONE=2'd1, GAP=2'd2);
  - SEL_OK/SEL_ERR;
  - counter widths CNT_W=24, BEEP_W=4.
- One natural sub-module `cycle_timer`:
  - load/value/done down-counter;
  - done when count==0 and not loading.
- FSM, arbitration and pending flags stay in `tone_sequencer`.

Test Plan (bench with TONE_CYC=10, GAP_CYC=3, OK_BEEPS=2, ERR_BEEPS=1):
- play_ok pulse at cycle 5 → en392 high cycles 6–15, low 16–18, high 19–28, low 29–31; busy 6–31; en110 never high.
- play_err pulse → en110 high exactly 10 cycles then 3 low; busy drops after the 13th cycle; en392 stays 0.
- play_ok and play_err same cycle → err beep first, then ok pattern with no IDLE cycle between; busy continuous for 13+26=39 cycles.
- Three play_ok pulses during an ok pattern → exactly one extra ok pattern follows (4 beeps total).
- rst asserted during second ok beep → en392/busy 0 next edge; no pending pattern plays afterwards.
- TONE_SEQ_PREEMPT_EN defined; play_err during first ok beep → en392 drops next edge, 3 gap cycles, then en110 for 10 cycles; no further 392 beeps.

Source files
------------

// File: rtl/tone_seq_pkg.sv
// Shared types and constants for the tone sequencer.
// Contents: FSM state type, pattern select encoding, counter widths.
package tone_seq_pkg;

  localparam int unsigned CNT_W  = 24;
  localparam int unsigned BEEP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic SEL_OK  = 1'b0;
  localparam logic SEL_ERR = 1'b1;

endpackage

// File: rtl/cycle_timer.sv
// Down-counter used to time tone and gap phases.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   load     : force count to value this edge
//   run      : count down while high; at zero, reload from value
//   value    : reload / load value
//   zero     : count is currently zero
//   done     : count is zero and no load is being applied
module cycle_timer
  import tone_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] value,
  output logic             zero,
  output logic             done
);

  logic [CNT_W-1:0] count;

  assign zero = (count == '0);
  assign done = zero & ~load;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (run) begin
      // Expiry and reload happen on the same edge so phases chain
      // back-to-back without a dead cycle.
      if (zero) count <= value;
      else      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Turns single-cycle ok/err result pulses into timed beep patterns for the
// tone generator, arbitrating both requesters onto one tone resource.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   play_ok   : request ok pattern (OK_BEEPS beeps of 392 Hz), pulse
//   play_err  : request err pattern (ERR_BEEPS beeps of 110 Hz), pulse
//   en392     : 392 Hz tone enable, registered
//   en110     : 110 Hz tone enable, registered
//   busy      : pattern playing or request pending, registered
// Build option: define TONE_SEQ_PREEMPT_EN to let play_err abort an ok
// pattern in progress.
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int unsigned TONE_CYC  = 12500000,
  parameter int unsigned GAP_CYC   = 1250000,
  parameter int unsigned OK_BEEPS  = 2,
  parameter int unsigned ERR_BEEPS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic play_ok,
  input  logic play_err,
  output logic en392,
  output logic en110,
  output logic busy
);

  localparam logic [CNT_W-1:0]  TONE_LD    = CNT_W'(TONE_CYC - 1);
  localparam logic [CNT_W-1:0]  GAP_LD     = CNT_W'(GAP_CYC - 1);
  localparam logic [BEEP_W-1:0] OK_LEFT    = BEEP_W'(OK_BEEPS - 1);
  localparam logic [BEEP_W-1:0] ERR_LEFT   = BEEP_W'(ERR_BEEPS - 1);
  localparam logic [BEEP_W-1:0] ERR_RELOAD = BEEP_W'(ERR_BEEPS);

  state_t            state;
  logic              sel;
  logic [BEEP_W-1:0] beeps;     // beeps still to play after the current one
  logic              pend_ok;
  logic              pend_err;

  logic              tmr_load;
  logic              tmr_run;
  logic [CNT_W-1:0]  tmr_value;
  logic              zero;
  logic              done;

  logic              err_req;
  logic              ok_req;
  logic              any_req;
  logic              start;
  logic              preempt;

  assign err_req = play_err | pend_err;
  assign ok_req  = play_ok  | pend_ok;
  assign any_req = err_req  | ok_req;

  // A new pattern starts from IDLE, or straight out of the final gap of the
  // previous pattern so a queued request follows without an idle cycle.
  assign start = any_req &
                 ((state == IDLE) | ((state == GAP) & done & (beeps == '0)));

`ifdef TONE_SEQ_PREEMPT_EN
  // Abort only while the ok pattern still has cycles left; on the very last
  // gap cycle the err request is simply served next by the start path.
  // zero (not done) is used here because done depends on the load this
  // signal drives.
  assign preempt = play_err & (sel == SEL_OK) &
                   ((state == TONE) |
                    ((state == GAP) & ~(zero & (beeps == '0))));
`else
  logic zero_unused;
  assign zero_unused = zero;
  assign preempt     = 1'b0;
`endif

  assign tmr_load = preempt | ((state == IDLE) & any_req);
  assign tmr_run  = (state != IDLE);

  // Value taken on an explicit load or on auto-reload at expiry.
  always_comb begin
    tmr_value = '0;
    if (preempt) begin
      tmr_value = GAP_LD;
    end else begin
      case (state)
        IDLE:    tmr_value = TONE_LD;
        TONE:    tmr_value = GAP_LD;
        GAP:     tmr_value = ((beeps != '0) | any_req) ? TONE_LD : '0;
        default: tmr_value = '0;
      endcase
    end
  end

  cycle_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .run   (tmr_run),
    .value (tmr_value),
    .zero  (zero),
    .done  (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= SEL_OK;
      beeps    <= '0;
      pend_ok  <= 1'b0;
      pend_err <= 1'b0;
      en392    <= 1'b0;
      en110    <= 1'b0;
      busy     <= 1'b0;
    end else if (preempt) begin
      state    <= GAP;
      sel      <= SEL_ERR;
      beeps    <= ERR_RELOAD;
      en392    <= 1'b0;
      en110    <= 1'b0;
      pend_ok  <= ok_req;
    end else if (start) begin
      // err wins arbitration; a simultaneous ok stays queued.
      state    <= TONE;
      busy     <= 1'b1;
      sel      <= err_req ? SEL_ERR : SEL_OK;
      beeps    <= err_req ? ERR_LEFT : OK_LEFT;
      en392    <= ~err_req;
      en110    <= err_req;
      pend_err <= 1'b0;
      pend_ok  <= err_req ? ok_req : 1'b0;
    end else begin
      case (state)
        TONE: begin
          pend_ok  <= ok_req;
          pend_err <= err_req;
          if (done) begin
            state <= GAP;
            en392 <= 1'b0;
            en110 <= 1'b0;
          end
        end
        GAP: begin
          pend_ok  <= ok_req;
          pend_err <= err_req;
          if (done) begin
            if (beeps != '0) begin
              state <= TONE;
              beeps <= beeps - BEEP_W'(1);
              en392 <= (sel == SEL_OK);
              en110 <= (sel == SEL_ERR);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;

  localparam int TONE = 10;
  localparam int GAPC = 3;
  localparam int OKB  = 2;
  localparam int ERRB = 1;

  logic clk;
  logic rst;
  logic play_ok;
  logic play_err;
  logic en392;
  logic en110;
  logic busy;

  int checks;
  int failures;

  // Reference model: a queue of per-cycle output codes (0 silent, 1 ok tone,
  // 2 err tone) built from whole patterns, plus one pending flag per type.
  int q[$];
  int cur_type;
  bit m_pend_ok;
  bit m_pend_err;
  bit e392;
  bit e110;
  bit ebusy;

  int h392;
  int h110;
  int hbusy;

  tone_sequencer #(
    .TONE_CYC  (TONE),
    .GAP_CYC   (GAPC),
    .OK_BEEPS  (OKB),
    .ERR_BEEPS (ERRB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .play_ok  (play_ok),
    .play_err (play_err),
    .en392    (en392),
    .en110    (en110),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_pattern(input int t);
    int n;
    n = (t == 1) ? ERRB : OKB;
    cur_type = t;
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < TONE; i++) q.push_back(t == 1 ? 2 : 1);
      for (int i = 0; i < GAPC; i++) q.push_back(0);
    end
  endtask

  task automatic model_step(input bit ok, input bit err, input bit r);
    int c;
    if (r) begin
      q.delete();
      m_pend_ok  = 0;
      m_pend_err = 0;
    end else if (q.size() == 0) begin
      if (err || m_pend_err) begin
        push_pattern(1);
        m_pend_err = 0;
        m_pend_ok  = m_pend_ok | ok;
      end else if (ok || m_pend_ok) begin
        push_pattern(0);
        m_pend_ok = 0;
      end
    end else begin
`ifdef TONE_SEQ_PREEMPT_EN
      if (cur_type == 0 && err) begin
        q.delete();
        for (int i = 0; i < GAPC; i++) q.push_back(0);
        push_pattern(1);
        m_pend_ok = m_pend_ok | ok;
      end else begin
        m_pend_ok  = m_pend_ok | ok;
        m_pend_err = m_pend_err | err;
      end
`else
      m_pend_ok  = m_pend_ok | ok;
      m_pend_err = m_pend_err | err;
`endif
    end
    if (q.size() > 0) begin
      c     = q.pop_front();
      e392  = (c == 1);
      e110  = (c == 2);
      ebusy = 1'b1;
    end else begin
      e392  = 1'b0;
      e110  = 1'b0;
      ebusy = 1'b0;
    end
  endtask

  task automatic tick(input bit ok, input bit err, input bit r);
    play_ok  = ok;
    play_err = err;
    rst      = r;
    @(posedge clk);
    model_step(ok, err, r);
    #1;
    checks++;
    assert (en392 === e392) else begin
      failures++;
      $error("FAIL en392 t=%0t got=%b exp=%b", $time, en392, e392);
    end
    checks++;
    assert (en110 === e110) else begin
      failures++;
      $error("FAIL en110 t=%0t got=%b exp=%b", $time, en110, e110);
    end
    checks++;
    assert (busy === ebusy) else begin
      failures++;
      $error("FAIL busy t=%0t got=%b exp=%b", $time, busy, ebusy);
    end
    checks++;
    assert ((en392 & en110) === 1'b0) else begin
      failures++;
      $error("FAIL excl t=%0t got=%b exp=0", $time, en392 & en110);
    end
    h392  += int'(en392 === 1'b1);
    h110  += int'(en110 === 1'b1);
    hbusy += int'(busy === 1'b1);
    play_ok  = 1'b0;
    play_err = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_tally();
    h392  = 0;
    h110  = 0;
    hbusy = 0;
  endtask

  task automatic expect_count(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    m_pend_ok  = 0;
    m_pend_err = 0;
    cur_type   = 0;
    play_ok    = 1'b0;
    play_err   = 1'b0;
    rst        = 1'b1;

    // Reset state
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    clear_tally();
    idle(4);

    // Single ok pattern: two 10-cycle beeps, each followed by 3 silent cycles
    clear_tally();
    tick(1'b1, 1'b0, 1'b0);
    idle(35);
    expect_count("ok_392_cycles", h392, OKB * TONE);
    expect_count("ok_110_cycles", h110, 0);
    expect_count("ok_busy_cycles", hbusy, OKB * (TONE + GAPC));

    // Single err pattern
    clear_tally();
    tick(1'b0, 1'b1, 1'b0);
    idle(20);
    expect_count("err_110_cycles", h110, ERRB * TONE);
    expect_count("err_392_cycles", h392, 0);
    expect_count("err_busy_cycles", hbusy, ERRB * (TONE + GAPC));

    // Simultaneous requests: err first, then ok with no idle cycle
    clear_tally();
    tick(1'b1, 1'b1, 1'b0);
    idle(50);
    expect_count("both_busy_cycles", hbusy, 39);
    expect_count("both_110_cycles", h110, TONE);
    expect_count("both_392_cycles", h392, 2 * TONE);

    // Repeated ok requests while playing collapse into one extra pattern
    clear_tally();
    tick(1'b1, 1'b0, 1'b0);
    idle(2);
    tick(1'b1, 1'b0, 1'b0);
    idle(4);
    tick(1'b1, 1'b0, 1'b0);
    idle(6);
    tick(1'b1, 1'b0, 1'b0);
    idle(70);
    expect_count("collapse_392_cycles", h392, 4 * TONE);

    // Reset during the second ok beep discards pattern and pending request
    tick(1'b1, 1'b0, 1'b0);
    idle(3);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    idle(TONE + GAPC);
    tick(1'b0, 1'b0, 1'b1);
    clear_tally();
    idle(60);
    expect_count("post_rst_392", h392, 0);
    expect_count("post_rst_110", h110, 0);
    expect_count("post_rst_busy", hbusy, 0);

    // play_err during the first ok beep
    clear_tally();
    tick(1'b1, 1'b0, 1'b0);
    idle(4);
    tick(1'b0, 1'b1, 1'b0);
    idle(50);
`ifdef TONE_SEQ_PREEMPT_EN
    expect_count("preempt_392_cycles", h392, 5);
    expect_count("preempt_busy_cycles", hbusy, 5 + GAPC + TONE + GAPC);
`else
    expect_count("queued_392_cycles", h392, OKB * TONE);
    expect_count("queued_busy_cycles", hbusy, OKB * (TONE + GAPC) + TONE + GAPC);
`endif
    expect_count("err_after_ok_110", h110, TONE);

    // Randomized pulses and occasional resets against the model
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 799) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
